// File: rtl/mem_fifo_pkg.sv
// Shared widths, types and defaults for the memory-backed FIFO controller.
package mem_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;
    localparam int AF_THRESH_DEF  = 28;

    typedef logic [ADDR_WIDTH_DEF-1:0] ptr_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/wrap_ptr.sv
// Wrapping pointer register with increment enable and load; exposes next and current value.
module wrap_ptr
    import mem_fifo_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] ptr_d_o,
    output logic [WIDTH-1:0] ptr_q_o
);

    logic [WIDTH-1:0] ptr_d;
    logic [WIDTH-1:0] ptr_q;

    // NOTE: the default assignment first means every path drives ptr_d, so no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (en_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_d_o = ptr_d;
    assign ptr_q_o = ptr_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around an always-writing, registered-read-address memory.
module mem_fifo_ctrl
    import mem_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_THRESH  = AF_THRESH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  almost_full,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // The slot under wr_ptr is always free, so one slot is sacrificed: full is all-ones.
    localparam logic [ADDR_WIDTH-1:0] CNT_FULL = '1;
    localparam logic [ADDR_WIDTH-1:0] AF_LVL   = ADDR_WIDTH'(AF_THRESH);

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH-1:0] count_d;
    logic [ADDR_WIDTH-1:0] count_q;
    logic                  af_d;
    logic                  af_q;

    assign in_ready  = ~flush & (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    wrap_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clock      (clock),
        .reset      (reset),
        .en_i       (push),
        .load_i     (1'b0),
        .load_val_i (wr_ptr_q),
        .ptr_d_o    (wr_ptr_d),
        .ptr_q_o    (wr_ptr_q)
    );

    // Flush has priority over pop inside wrap_ptr, so a same-cycle pop is absorbed.
    wrap_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clock      (clock),
        .reset      (reset),
        .en_i       (pop),
        .load_i     (flush),
        .load_val_i (wr_ptr_q),
        .ptr_d_o    (rd_ptr_d),
        .ptr_q_o    (rd_ptr_q)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + ADDR_WIDTH'(1);
        end else if (!push && pop) begin
            count_d = count_q - ADDR_WIDTH'(1);
        end
        af_d = (count_d >= AF_LVL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            af_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            af_q    <= af_d;
        end
    end

    // The memory registers its read address, so feeding it the next read pointer
    // makes mem_rdata track mem[rd_ptr] with no extra cycle of latency.
    assign mem_raddr   = rd_ptr_d;
    assign mem_waddr   = wr_ptr_q;
    assign mem_wdata   = in_data;
    assign out_data    = mem_rdata;
    assign count       = count_q;
    assign almost_full = af_q;

    unused_wr_next: assert property (@(posedge clock) disable iff (!reset)
        count_q == ADDR_WIDTH'(wr_ptr_q - rd_ptr_q));

    no_pop_when_empty: assert property (@(posedge clock) disable iff (!reset)
        !(pop && count_q == '0));

    no_push_when_full: assert property (@(posedge clock) disable iff (!reset)
        !(push && count_q == CNT_FULL));

    logic unused_wr_d;
    assign unused_wr_d = ^wr_ptr_d;

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Scoreboard bench for mem_fifo_ctrl with a behavioural always-write, registered-read memory.
module tb_mem_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [AW-1:0] count;
    logic          almost_full;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem_model [32];
    logic [AW-1:0] raddr_q;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clock = ~clock;

    mem_fifo_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clock) begin
        mem_model[mem_waddr] <= mem_wdata;
        raddr_q              <= mem_raddr;
    end
    assign mem_rdata = mem_model[raddr_q];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},     32'(count),       32'd0);
        check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        check({tag, "_af"},        32'(almost_full), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),    32'd1);
        check({tag, "_waddr"},     32'(mem_waddr),   32'd0);
        check({tag, "_raddr"},     32'(mem_raddr),   32'd0);
    endtask

    // Monitor: every accepted output is matched against the oldest expected entry.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got 0x%08h expected no output", out_data);
            end else begin
                check("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #12;
        check_reset_outputs("rst");
        @(posedge clock);
        #1 reset = 1'b1;

        // Single entry under backpressure.
        push_word(32'hDEAD_BEEF);
        #1;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_count", 32'(count), 32'd1);
        check("single_data", out_data, 32'hDEAD_BEEF);
        repeat (5) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, 32'hDEAD_BEEF);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("single_drained", 32'(count), 32'd0);

        // Fill to capacity, probe the threshold and overflow, then drain in order.
        for (int i = 0; i < 31; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            exp_q.push_back(32'(i));
            tick();
            #1;
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'((i + 1) >= 28));
            check("fill_in_ready", 32'(in_ready), 32'((i + 1) != 31));
        end
        in_data = 32'h0000_0099;
        tick();
        #1;
        check("overflow_count", 32'(count), 32'd31);
        check("overflow_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (31) tick();
        out_ready = 1'b0;
        #1;
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_af", 32'(almost_full), 32'd0);

        // Streaming with pointer wrap: one push and one pop per cycle.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_data = 32'h1000 + 32'(c);
            exp_q.push_back(in_data);
            tick();
            #1;
            check("stream_count", 32'(count), 32'd1);
            check("stream_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        #1;
        check("stream_end_count", 32'(count), 32'd0);

        // Flush with a concurrent push and pop attempt.
        for (int i = 0; i < 10; i++) push_word(32'h200 + 32'(i));
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_AAAA;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready_after", 32'(in_ready), 32'd1);
        push_word(32'h55);
        #1;
        check("post_flush_data", out_data, 32'h55);
        check("post_flush_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("post_flush_count", 32'(count), 32'd0);

        // Idle cycles on a full FIFO must only write the free slot.
        for (int i = 0; i < 31; i++) push_word(32'h300 + 32'(i * 7));
        repeat (20) begin
            in_data = $urandom;
            tick();
        end
        #1;
        check("idle_count", 32'(count), 32'd31);
        out_ready = 1'b1;
        repeat (31) tick();
        out_ready = 1'b0;
        #1;
        check("idle_drain_count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle with entries queued.
        for (int i = 0; i < 12; i++) push_word(32'h400 + 32'(i));
        #1;
        check("prereset_count", 32'(count), 32'd12);
        @(posedge clock);
        #3 reset = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        tick();
        reset = 1'b1;
        push_word(32'h77);
        push_word(32'h78);
        #1;
        check("post_reset_head", out_data, 32'h77);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        check("post_reset_count", 32'(count), 32'd0);

        check("leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
